udma_rx_chan_core: RTL

- Single uDMA receive channel: the inbound counterpart of the uDMA Tx channels block.
- Accepts a valid/ready data stream from a peripheral, buffers it in a small FIFO and writes it to L2 memory through a req/gnt port.
- Address and remaining-byte counters are loaded from channel configuration, with one-deep pending-transfer queueing and a continuous (auto-reload) mode.
- Sits between a peripheral RX datapath and the uDMA L2 write arbiter.

---
 rtl/udma_rx_chan_core.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/udma_rx_chan_core.sv
// udma_rx_chan_core: single uDMA receive channel.
// Takes a valid/ready stream from a peripheral, buffers it in a small FIFO and
// writes it to L2 through a req/gnt port, tracking address and remaining bytes.
// A transfer issued while busy is parked in a one-deep pending slot; continuous
// mode reloads the original start/size when a transfer completes.
module udma_rx_chan_core #(
    parameter int L2_AWIDTH  = 19,
    parameter int TRANS_SIZE = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [L2_AWIDTH-1:0]  cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cfg_continuous_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    output logic [L2_AWIDTH-1:0]  cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0] cfg_bytes_left_o,
    output logic                  cfg_en_o,
    output logic                  cfg_pending_o,
    input  logic [31:0]           data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  l2_req_o,
    input  logic                  l2_gnt_i,
    output logic [L2_AWIDTH-1:0]  l2_addr_o,
    output logic [31:0]           l2_wdata_o,
    output logic [3:0]            l2_be_o,
    output logic                  ch_event_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    function automatic logic [2:0] beat_of(input logic [1:0] ds);
        case (ds)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [L2_AWIDTH-1:0] align_addr(input logic [L2_AWIDTH-1:0] a,
                                                        input logic [1:0] ds);
        logic [L2_AWIDTH-1:0] r;
        r = a;
        if (ds == 2'b01) r[0] = 1'b0;
        else if (ds[1])  r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [TRANS_SIZE-1:0] align_size(input logic [TRANS_SIZE-1:0] s,
                                                         input logic [1:0] ds);
        logic [TRANS_SIZE-1:0] r;
        r = s;
        if (ds == 2'b01) r[0] = 1'b0;
        else if (ds[1])  r[1:0] = 2'b00;
        return r;
    endfunction

    state_t                state_q, state_n;
    logic [L2_AWIDTH-1:0]  addr_q, orig_addr_q, pend_addr_q;
    logic [TRANS_SIZE-1:0] bytes_q, rx_q, orig_size_q, pend_size_q;
    logic [1:0]            ds_q, pend_ds_q;
    logic                  cont_q, pend_cont_q, pend_q, event_q;
    logic [PW:0]           wr_ptr_q, rd_ptr_q;
    logic [31:0]           mem [FIFO_DEPTH];

    logic                  running, fifo_full, fifo_empty, push, pop, done;
    logic                  ld_new, ld_pend, ld_orig, pend_set, pend_clr;
    logic [L2_AWIDTH-1:0]  beat_a, new_addr;
    logic [TRANS_SIZE-1:0] beat_t, new_size;
    logic [31:0]           head, wdata;
    logic [3:0]            be;

    assign running    = (state_q == RUN);
    assign beat_a     = L2_AWIDTH'(beat_of(ds_q));
    assign beat_t     = TRANS_SIZE'(beat_of(ds_q));
    assign new_addr   = align_addr(cfg_startaddr_i, cfg_datasize_i);
    assign new_size   = align_size(cfg_size_i, cfg_datasize_i);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = mem[rd_ptr_q[PW-1:0]];

    // clr kills both handshakes in its own cycle, so a coincident grant is lost
    assign ready_o  = running && !fifo_full && (rx_q != '0) && !cfg_clr_i;
    assign l2_req_o = running && !fifo_empty && !cfg_clr_i;
    assign push     = valid_i && ready_o;
    assign pop      = l2_req_o && l2_gnt_i;
    // a zero-length transfer completes on its first RUN cycle
    assign done     = running && !cfg_clr_i &&
                      ((bytes_q == '0) || (pop && (bytes_q == beat_t)));

    assign cfg_curr_addr_o  = addr_q;
    assign cfg_bytes_left_o = bytes_q;
    assign cfg_en_o         = running;
    assign cfg_pending_o    = pend_q;
    assign ch_event_o       = event_q;
    assign l2_addr_o        = {addr_q[L2_AWIDTH-1:2], 2'b00};
    assign l2_wdata_o       = l2_req_o ? wdata : 32'h0;
    assign l2_be_o          = l2_req_o ? be : 4'h0;

    // replicate the beat across the word and place byte enables by address lane
    always_comb begin
        wdata = head;
        be    = 4'b1111;
        case (ds_q)
            2'b00: begin wdata = {4{head[7:0]}};  be = 4'b0001 << addr_q[1:0]; end
            2'b01: begin wdata = {2{head[15:0]}}; be = 4'b0011 << addr_q[1:0]; end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_n;
    end

    // next state and load selection; an en during completion with a slot
    // already parked refills the slot after it is consumed
    always_comb begin
        state_n  = state_q;
        ld_new   = 1'b0;
        ld_pend  = 1'b0;
        ld_orig  = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        if (cfg_clr_i) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cfg_en_i) begin ld_new = 1'b1; state_n = RUN; end
                RUN: begin
                    if (done) begin
                        if (pend_q) begin
                            ld_pend  = 1'b1;
                            pend_clr = 1'b1;
                            pend_set = cfg_en_i;
                        end else if (cfg_en_i) ld_new  = 1'b1;
                        else if (cont_q)       ld_orig = 1'b1;
                        else                   state_n = IDLE;
                    end else if (cfg_en_i) begin
                        pend_set = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // counters, pending slot, event and FIFO pointers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q      <= '0;
            bytes_q     <= '0;
            rx_q        <= '0;
            ds_q        <= '0;
            cont_q      <= 1'b0;
            orig_addr_q <= '0;
            orig_size_q <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_size_q <= '0;
            pend_ds_q   <= '0;
            pend_cont_q <= 1'b0;
            event_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else if (cfg_clr_i) begin
            addr_q   <= '0;
            bytes_q  <= '0;
            rx_q     <= '0;
            pend_q   <= 1'b0;
            event_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            event_q <= done;
            if (ld_new) begin
                addr_q      <= new_addr;
                bytes_q     <= new_size;
                rx_q        <= new_size;
                ds_q        <= cfg_datasize_i;
                cont_q      <= cfg_continuous_i;
                orig_addr_q <= new_addr;
                orig_size_q <= new_size;
            end else if (ld_pend) begin
                addr_q      <= pend_addr_q;
                bytes_q     <= pend_size_q;
                rx_q        <= pend_size_q;
                ds_q        <= pend_ds_q;
                cont_q      <= pend_cont_q;
                orig_addr_q <= pend_addr_q;
                orig_size_q <= pend_size_q;
            end else if (ld_orig) begin
                addr_q  <= orig_addr_q;
                bytes_q <= orig_size_q;
                rx_q    <= orig_size_q;
            end else begin
                if (pop) begin
                    addr_q  <= addr_q + beat_a;
                    bytes_q <= bytes_q - beat_t;
                end
                if (push) rx_q <= rx_q - beat_t;
            end
            if (pend_set) begin
                pend_q      <= 1'b1;
                pend_addr_q <= new_addr;
                pend_size_q <= new_size;
                pend_ds_q   <= cfg_datasize_i;
                pend_cont_q <= cfg_continuous_i;
            end else if (pend_clr) begin
                pend_q <= 1'b0;
            end
            if (push) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
            if (pop)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q[PW-1:0]] <= data_i;
    end
endmodule
